// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, word type and byte-address decode for the data-memory stage
package memstage_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_BITS = 10;
  localparam int ADDR_LSB  = 2;

  typedef logic [DATA_W-1:0] word_t;

  // Drops the byte offset; anything above the index is truncated by the cast.
  function automatic logic [ADDR_BITS-1:0] addr_to_index(input logic [31:0] addr);
    return ADDR_BITS'(addr >> ADDR_LSB);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM-side access bus into the data-memory stage
interface mem_stage_if #(
  parameter int DATA_W = 32
);

  logic              Mem_WrEn;
  logic [31:0]       ALU_MEM_Addr;
  logic [DATA_W-1:0] MEM_DataIn;
  logic [DATA_W-1:0] MEM_DataOut;

  modport master (
    output Mem_WrEn,
    output ALU_MEM_Addr,
    output MEM_DataIn,
    input  MEM_DataOut
  );

  modport slave (
    input  Mem_WrEn,
    input  ALU_MEM_Addr,
    input  MEM_DataIn,
    output MEM_DataOut
  );

endinterface

// File: rtl/mem_stage_data_ram.sv
// rtl/mem_stage_data_ram.sv - single-port synchronous RAM, write-first registered output
module data_ram #(
  parameter int DATA_W    = memstage_pkg::DATA_W,
  parameter int ADDR_BITS = memstage_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_zero,
  input  logic [ADDR_BITS-1:0] index,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[index] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_zero) begin
      rd_data <= '0;
    end else if (wr_en) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[index];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS data-memory stage; optional MEMSTAGE_ADDR_CHECK_EN rejects addresses beyond the RAM
module mem_stage #(
  parameter int DATA_W    = memstage_pkg::DATA_W,
  parameter int ADDR_BITS = memstage_pkg::ADDR_BITS
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);
  import memstage_pkg::*;

  logic [ADDR_BITS-1:0] index;
  logic                 wr_en;
  logic                 rd_zero;

  generate
    if (ADDR_BITS == memstage_pkg::ADDR_BITS) begin : g_pkg_decode
      assign index = addr_to_index(bus.ALU_MEM_Addr);
    end else begin : g_param_decode
      assign index = ADDR_BITS'(bus.ALU_MEM_Addr >> ADDR_LSB);
    end
  endgenerate

`ifdef MEMSTAGE_ADDR_CHECK_EN
  logic in_range;

  // Any bit above the word index means the access falls outside the RAM.
  assign in_range = ((bus.ALU_MEM_Addr >> (ADDR_BITS + ADDR_LSB)) == 32'd0);
  assign wr_en    = bus.Mem_WrEn && in_range;
  assign rd_zero  = !in_range;
`else
  assign wr_en    = bus.Mem_WrEn;
  assign rd_zero  = 1'b0;
`endif

  data_ram #(
    .DATA_W    (DATA_W),
    .ADDR_BITS (ADDR_BITS)
  ) u_data_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .rd_zero (rd_zero),
    .index   (index),
    .wr_data (bus.MEM_DataIn),
    .rd_data (bus.MEM_DataOut)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;
  import memstage_pkg::*;

  localparam int EQ = 1;
  localparam int NE = 2;

  typedef struct {
    int          mode;
    logic [31:0] value;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_stage_if #(.DATA_W(DATA_W)) bus ();

  mem_stage #(
    .DATA_W    (DATA_W),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One call = one clock of stimulus plus the output expected after that edge.
  task automatic step(input logic r, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input int mode,
                      input logic [31:0] value, input string name);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.Mem_WrEn     = we;
    bus.ALU_MEM_Addr = addr;
    bus.MEM_DataIn   = data;
    e.mode  = mode;
    e.value = value;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        #2;
        if (e.mode == EQ) begin
          n_cmp++;
          if (bus.MEM_DataOut !== e.value) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", e.name, bus.MEM_DataOut, e.value);
          end
        end else if (e.mode == NE) begin
          n_cmp++;
          if (bus.MEM_DataOut === e.value) begin
            n_bad++;
            $display("FAIL %s: got %h expected anything but %h", e.name, bus.MEM_DataOut, e.value);
          end
        end
      end
    end
  end

  initial begin : stimulus
    bus.Mem_WrEn     = 1'b1;
    bus.ALU_MEM_Addr = 32'h4;
    bus.MEM_DataIn   = 32'hDEAD;

    step(1, 1, 32'h4,   32'hDEAD,     EQ, 32'h0,        "reset_out_0");
    step(1, 1, 32'h4,   32'hDEAD,     EQ, 32'h0,        "reset_out_1");
    step(0, 0, 32'h4,   32'h0,        NE, 32'hDEAD,     "reset_write_dropped");

    step(0, 1, 32'h4,   32'd31,       EQ, 32'd31,       "wr_4_first");
    step(0, 1, 32'h1,   32'd16,       EQ, 32'd16,       "wr_1_first");
    step(0, 0, 32'h4,   32'h0,        EQ, 32'd31,       "rd_4");
    step(0, 0, 32'h0,   32'h0,        EQ, 32'd16,       "rd_0_alias");
    step(0, 0, 32'h2,   32'h0,        EQ, 32'd16,       "rd_2_alias");

    step(0, 1, 32'hFC3, 32'hA5A5A5A5, EQ, 32'hA5A5A5A5, "wr_fc3_first");
    step(0, 0, 32'hFC0, 32'h0,        EQ, 32'hA5A5A5A5, "rd_fc0_idx1008");
    step(0, 1, 32'h8,   32'd7,        EQ, 32'd7,        "wr_8_first");
    step(0, 0, 32'h8,   32'h0,        EQ, 32'd7,        "rd_8");
    step(0, 1, 32'hFFC, 32'hFFFFFFFF, EQ, 32'hFFFFFFFF, "wr_top_first");
    step(0, 0, 32'hFFD, 32'h0,        EQ, 32'hFFFFFFFF, "rd_top");
    step(0, 0, 32'h4,   32'h0,        EQ, 32'd31,       "rd_4_untouched");

    // Reset in the middle of traffic: its write is lost, earlier data survives.
    step(0, 1, 32'hC,   32'h123,      EQ, 32'h123,      "wr_c_first");
    step(1, 1, 32'hC,   32'h99,       EQ, 32'h0,        "midreset_out");
    step(0, 0, 32'hC,   32'h0,        EQ, 32'h123,      "midreset_write_dropped");
    step(0, 0, 32'h8,   32'h0,        EQ, 32'd7,        "midreset_persist");

`ifdef MEMSTAGE_ADDR_CHECK_EN
    step(0, 1, 32'h1004, 32'h55,      EQ, 32'h0,        "oor_wr_out");
    step(0, 0, 32'h4,    32'h0,       EQ, 32'd31,       "oor_wr_dropped");
    step(0, 0, 32'h1004, 32'h0,       EQ, 32'h0,        "oor_rd_zero");
    step(0, 0, 32'h80000008, 32'h0,   EQ, 32'h0,        "oor_rd_msb_zero");
`else
    step(0, 1, 32'h1004, 32'h55,      EQ, 32'h55,       "alias_wr_first");
    step(0, 0, 32'h4,    32'h0,       EQ, 32'h55,       "alias_rd_4");
    step(0, 0, 32'h1004, 32'h0,       EQ, 32'h55,       "alias_rd_1004");
    step(0, 0, 32'h80000008, 32'h0,   EQ, 32'd7,        "alias_rd_msb");
`endif

    step(0, 0, 32'h0,   32'h0,        EQ, 32'd16,       "final_rd_0");

    @(negedge clk);
    bus.Mem_WrEn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
